bt_cmd_frame_ctrl: RTL and testbench

//  Sequences the byte stream from the Bluetooth UART receiver into fixed-size game command frames.

---
 rtl/bt_cmd_frame_ctrl.sv | 148 ++++++++++++++
 tb/tb_bt_cmd_frame_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_cmd_frame_ctrl.sv
// Frames the Bluetooth UART byte stream into SOF/ID/ARG0/ARG1/CHK game commands,
// checks the XOR checksum and drops frames that stall between bytes.
module bt_cmd_frame_ctrl #(
    parameter logic [7:0] SOF_BYTE   = 8'hAA,
    parameter int         TMO_W      = 16,
    parameter int         TMO_CYCLES = 50000
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       byte_avail,
    input  logic [7:0] byte_in,
    output logic       cmd_valid,
    output logic [7:0] cmd_id,
    output logic [7:0] cmd_arg0,
    output logic [7:0] cmd_arg1,
    output logic       err_chk,
    output logic       err_tmo,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        GET_ID,
        GET_A0,
        GET_A1,
        GET_CHK
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]       id_q, id_d;
    logic [7:0]       a0_q, a0_d;
    logic [7:0]       a1_q, a1_d;
    logic [7:0]       cmd_id_q, cmd_id_d;
    logic [7:0]       cmd_arg0_q, cmd_arg0_d;
    logic [7:0]       cmd_arg1_q, cmd_arg1_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             err_chk_q, err_chk_d;
    logic             err_tmo_q, err_tmo_d;
    logic             tmo_hit;
    logic [7:0]       chk_calc;

    // A byte landing on the terminal count wins over the timeout.
    assign tmo_hit  = (state_q != IDLE) && !byte_avail && (tmo_cnt_q == TMO_LAST);
    assign chk_calc = id_q ^ a0_q ^ a1_q;

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (byte_avail && (byte_in == SOF_BYTE)) state_d = GET_ID;
            GET_ID:  if (byte_avail) state_d = GET_A0;
            GET_A0:  if (byte_avail) state_d = GET_A1;
            GET_A1:  if (byte_avail) state_d = GET_CHK;
            GET_CHK: if (byte_avail) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        id_d        = id_q;
        a0_d        = a0_q;
        a1_d        = a1_q;
        cmd_id_d    = cmd_id_q;
        cmd_arg0_d  = cmd_arg0_q;
        cmd_arg1_d  = cmd_arg1_q;
        frame_cnt_d = frame_cnt_q;
        cmd_valid_d = 1'b0;
        err_chk_d   = 1'b0;
        err_tmo_d   = tmo_hit;
        tmo_cnt_d   = tmo_cnt_q + TMO_ONE;
        if ((state_q == IDLE) || byte_avail || tmo_hit) begin
            tmo_cnt_d = '0;
        end
        if (byte_avail) begin
            case (state_q)
                GET_ID: id_d = byte_in;
                GET_A0: a0_d = byte_in;
                GET_A1: a1_d = byte_in;
                GET_CHK: begin
                    if (byte_in == chk_calc) begin
                        cmd_valid_d = 1'b1;
                        cmd_id_d    = id_q;
                        cmd_arg0_d  = a0_q;
                        cmd_arg1_d  = a1_q;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        err_chk_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            id_q        <= '0;
            a0_q        <= '0;
            a1_q        <= '0;
            cmd_id_q    <= '0;
            cmd_arg0_q  <= '0;
            cmd_arg1_q  <= '0;
            frame_cnt_q <= '0;
            cmd_valid_q <= 1'b0;
            err_chk_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            id_q        <= id_d;
            a0_q        <= a0_d;
            a1_q        <= a1_d;
            cmd_id_q    <= cmd_id_d;
            cmd_arg0_q  <= cmd_arg0_d;
            cmd_arg1_q  <= cmd_arg1_d;
            frame_cnt_q <= frame_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            err_chk_q   <= err_chk_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign cmd_valid = cmd_valid_q;
    assign err_chk   = err_chk_q;
    assign err_tmo   = err_tmo_q;
    assign cmd_id    = cmd_id_q;
    assign cmd_arg0  = cmd_arg0_q;
    assign cmd_arg1  = cmd_arg1_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bt_cmd_frame_ctrl.sv
// Self-checking bench for bt_cmd_frame_ctrl: a frame-level reference model pushes
// expected pulses into a scoreboard that is drained as the DUT produces them.
module tb_bt_cmd_frame_ctrl;

    localparam int TMO    = 8;
    localparam int K_GOOD = 1;
    localparam int K_CHK  = 2;
    localparam int K_TMO  = 3;

    logic       clk_div = 1'b0;
    logic       rst;
    logic       byte_avail;
    logic [7:0] byte_in;
    logic       cmd_valid;
    logic [7:0] cmd_id;
    logic [7:0] cmd_arg0;
    logic [7:0] cmd_arg1;
    logic       err_chk;
    logic       err_tmo;
    logic       busy;
    logic [7:0] frame_cnt;

    typedef struct packed {
        int kind;
        int cyc;
    } exp_t;

    exp_t sb[$];

    int checks    = 0;
    int passed    = 0;
    int cyc       = 0;
    int good_seen = 0;

    // Reference model: frame position, scratch bytes, idle-gap length, last good command
    int         m_st;
    int         m_gap;
    logic [7:0] m_id, m_a0, m_a1;
    logic [7:0] m_cmd_id, m_cmd_a0, m_cmd_a1, m_cnt;

    bt_cmd_frame_ctrl #(
        .SOF_BYTE  (8'hAA),
        .TMO_W     (16),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk_div   (clk_div),
        .rst       (rst),
        .byte_avail(byte_avail),
        .byte_in   (byte_in),
        .cmd_valid (cmd_valid),
        .cmd_id    (cmd_id),
        .cmd_arg0  (cmd_arg0),
        .cmd_arg1  (cmd_arg1),
        .err_chk   (err_chk),
        .err_tmo   (err_tmo),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk_div = ~clk_div;

    task automatic model_clear();
        m_st     = 0;
        m_gap    = 0;
        m_id     = 8'h00;
        m_a0     = 8'h00;
        m_a1     = 8'h00;
        m_cmd_id = 8'h00;
        m_cmd_a0 = 8'h00;
        m_cmd_a1 = 8'h00;
        m_cnt    = 8'h00;
        sb.delete();
    endtask

    task automatic model_step();
        exp_t e;
        if (!rst) begin
            e.cyc = cyc + 1;
            if (m_st == 0) begin
                if (byte_avail && byte_in == 8'hAA) begin
                    m_st  = 1;
                    m_gap = 0;
                end
            end else if (byte_avail) begin
                m_gap = 0;
                case (m_st)
                    1: m_id = byte_in;
                    2: m_a0 = byte_in;
                    3: m_a1 = byte_in;
                    default: begin
                        if (byte_in == (m_id ^ m_a0 ^ m_a1)) begin
                            m_cmd_id = m_id;
                            m_cmd_a0 = m_a0;
                            m_cmd_a1 = m_a1;
                            m_cnt    = m_cnt + 8'd1;
                            e.kind   = K_GOOD;
                        end else begin
                            e.kind = K_CHK;
                        end
                        sb.push_back(e);
                    end
                endcase
                m_st = (m_st == 4) ? 0 : m_st + 1;
            end else begin
                m_gap = m_gap + 1;
                if (m_gap == TMO) begin
                    e.kind = K_TMO;
                    sb.push_back(e);
                    m_st = 0;
                end
            end
        end
    endtask

    // One clock: advance the model, then sample outputs 1ns after the edge
    task automatic tick();
        int   ev;
        int   kind;
        exp_t e;
        model_step();
        @(posedge clk_div);
        #1;
        cyc = cyc + 1;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks = checks + 1;
            $display("[TB] FAIL missing_pulse cyc=%0d: got nothing, required kind %0d at cyc %0d",
                     cyc, sb[0].kind, sb[0].cyc);
            void'(sb.pop_front());
        end
        ev = 32'(cmd_valid) + 32'(err_chk) + 32'(err_tmo);
        checks = checks + 1;
        if (ev > 1) begin
            $display("[TB] FAIL exclusive cyc=%0d: got valid/chk/tmo=%b%b%b, required at most one",
                     cyc, cmd_valid, err_chk, err_tmo);
        end else begin
            passed = passed + 1;
        end
        if (ev > 0) begin
            kind = cmd_valid ? K_GOOD : (err_chk ? K_CHK : K_TMO);
            if (kind == K_GOOD) good_seen = good_seen + 1;
            checks = checks + 1;
            if (sb.size() == 0) begin
                $display("[TB] FAIL unexpected_pulse cyc=%0d: got kind %0d, required none", cyc, kind);
            end else begin
                e = sb.pop_front();
                if (kind != e.kind || cyc != e.cyc) begin
                    $display("[TB] FAIL pulse cyc=%0d: got kind %0d, required kind %0d at cyc %0d",
                             cyc, kind, e.kind, e.cyc);
                end else begin
                    passed = passed + 1;
                end
            end
        end
        checks = checks + 1;
        if ({cmd_id, cmd_arg0, cmd_arg1, frame_cnt, busy} !==
            {m_cmd_id, m_cmd_a0, m_cmd_a1, m_cnt, (m_st != 0)}) begin
            $display("[TB] FAIL outputs cyc=%0d: got id=%h a0=%h a1=%h cnt=%0d busy=%b, required id=%h a0=%h a1=%h cnt=%0d busy=%b",
                     cyc, cmd_id, cmd_arg0, cmd_arg1, frame_cnt, busy,
                     m_cmd_id, m_cmd_a0, m_cmd_a1, m_cnt, (m_st != 0));
        end else begin
            passed = passed + 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_avail = 1'b1;
        byte_in    = b;
        tick();
        byte_avail = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [7:0] a0,
                              input logic [7:0] a1, input logic [7:0] chk);
        send_byte(8'hAA);
        send_byte(id);
        send_byte(a0);
        send_byte(a1);
        send_byte(chk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic expect_drained(input string name);
        idle(2);
        checks = checks + 1;
        if (sb.size() != 0) begin
            $display("[TB] FAIL %s_drained: got %0d pending pulses, required 0", name, sb.size());
            sb.delete();
        end else begin
            passed = passed + 1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks = checks + 1;
        if ({cmd_valid, err_chk, err_tmo, busy, cmd_id, cmd_arg0, cmd_arg1, frame_cnt} !== 36'd0) begin
            $display("[TB] FAIL reset_state: got valid=%b chk=%b tmo=%b busy=%b id=%h a0=%h a1=%h cnt=%h, required all zero",
                     cmd_valid, err_chk, err_tmo, busy, cmd_id, cmd_arg0, cmd_arg1, frame_cnt);
        end else begin
            passed = passed + 1;
        end
    endtask

    task automatic test_good_frame();
        send_frame(8'h01, 8'h10, 8'h20, 8'h31);
        checks = checks + 1;
        if ({cmd_valid, cmd_id, cmd_arg0, cmd_arg1, frame_cnt} !== {1'b1, 8'h01, 8'h10, 8'h20, 8'd1}) begin
            $display("[TB] FAIL good_frame: got valid=%b id=%h a0=%h a1=%h cnt=%0d, required 1 01 10 20 1",
                     cmd_valid, cmd_id, cmd_arg0, cmd_arg1, frame_cnt);
        end else begin
            passed = passed + 1;
        end
        tick();
        checks = checks + 1;
        if (cmd_valid !== 1'b0) begin
            $display("[TB] FAIL good_pulse_width: got cmd_valid=%b, required 0", cmd_valid);
        end else begin
            passed = passed + 1;
        end
        expect_drained("good_frame");
    endtask

    task automatic test_bad_checksum();
        send_frame(8'h01, 8'h10, 8'h20, 8'h32);
        checks = checks + 1;
        if ({err_chk, cmd_valid, cmd_id, frame_cnt} !== {1'b1, 1'b0, 8'h01, 8'd1}) begin
            $display("[TB] FAIL bad_checksum: got chk=%b valid=%b id=%h cnt=%0d, required 1 0 01 1",
                     err_chk, cmd_valid, cmd_id, frame_cnt);
        end else begin
            passed = passed + 1;
        end
        expect_drained("bad_checksum");
    endtask

    task automatic test_timeout();
        send_byte(8'hAA);
        send_byte(8'h05);
        idle(TMO - 1);
        checks = checks + 1;
        if ({err_tmo, busy} !== 2'b01) begin
            $display("[TB] FAIL timeout_early: got tmo=%b busy=%b, required 0 1", err_tmo, busy);
        end else begin
            passed = passed + 1;
        end
        tick();
        checks = checks + 1;
        if ({err_tmo, busy} !== 2'b10) begin
            $display("[TB] FAIL timeout_pulse: got tmo=%b busy=%b, required 1 0", err_tmo, busy);
        end else begin
            passed = passed + 1;
        end
        idle(4);
        send_frame(8'hAA, 8'h05, 8'h00, 8'h00);
        send_frame(8'h05, 8'h00, 8'h00, 8'h05);
        expect_drained("timeout");
    endtask

    task automatic test_terminal_count();
        logic [7:0] seq [5];
        seq[0] = 8'hAA;
        seq[1] = 8'h01;
        seq[2] = 8'h02;
        seq[3] = 8'h03;
        seq[4] = 8'h00;
        for (int i = 0; i < 5; i++) begin
            send_byte(seq[i]);
            if (i < 4) idle(TMO - 1);
        end
        checks = checks + 1;
        if ({cmd_valid, err_tmo, cmd_id, cmd_arg1} !== {1'b1, 1'b0, 8'h01, 8'h03}) begin
            $display("[TB] FAIL terminal_count: got valid=%b tmo=%b id=%h a1=%h, required 1 0 01 03",
                     cmd_valid, err_tmo, cmd_id, cmd_arg1);
        end else begin
            passed = passed + 1;
        end
        expect_drained("terminal_count");
    endtask

    task automatic test_sof_as_data();
        logic [7:0] seq [7];
        logic [7:0] cnt_before;
        cnt_before = frame_cnt;
        seq[0] = 8'h55; seq[1] = 8'h00; seq[2] = 8'hAA; seq[3] = 8'hAA;
        seq[4] = 8'hAA; seq[5] = 8'hAA; seq[6] = 8'h00;
        for (int i = 0; i < 7; i++) send_byte(seq[i]);
        checks = checks + 1;
        if ({err_chk, cmd_valid, frame_cnt} !== {1'b1, 1'b0, cnt_before}) begin
            $display("[TB] FAIL sof_as_data: got chk=%b valid=%b cnt=%0d, required 1 0 %0d",
                     err_chk, cmd_valid, frame_cnt, cnt_before);
        end else begin
            passed = passed + 1;
        end
        expect_drained("sof_as_data");
    endtask

    task automatic test_mid_frame_reset();
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h10);
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if ({cmd_valid, err_chk, err_tmo, busy, cmd_id, frame_cnt} !== 20'd0) begin
            $display("[TB] FAIL async_reset: got valid=%b chk=%b tmo=%b busy=%b id=%h cnt=%h, required all zero",
                     cmd_valid, err_chk, err_tmo, busy, cmd_id, frame_cnt);
        end else begin
            passed = passed + 1;
        end
        model_clear();
        tick();
        rst = 1'b0;
        idle(TMO + 2);
        send_frame(8'h7E, 8'h42, 8'h99, 8'h7E ^ 8'h42 ^ 8'h99);
        checks = checks + 1;
        if ({cmd_valid, cmd_id, cmd_arg0, cmd_arg1, frame_cnt} !== {1'b1, 8'h7E, 8'h42, 8'h99, 8'd1}) begin
            $display("[TB] FAIL after_reset_frame: got valid=%b id=%h a0=%h a1=%h cnt=%0d, required 1 7e 42 99 1",
                     cmd_valid, cmd_id, cmd_arg0, cmd_arg1, frame_cnt);
        end else begin
            passed = passed + 1;
        end
        expect_drained("mid_frame_reset");
    endtask

    task automatic test_back_to_back();
        int         good_before;
        logic [7:0] id, a0, a1;
        apply_reset();
        good_before = good_seen;
        for (int i = 0; i < 256; i++) begin
            id = 8'($urandom_range(0, 255));
            a0 = 8'($urandom_range(0, 255));
            a1 = 8'(i);
            send_frame(id, a0, a1, id ^ a0 ^ a1);
        end
        expect_drained("back_to_back");
        checks = checks + 1;
        if (good_seen - good_before != 256 || frame_cnt !== 8'd0) begin
            $display("[TB] FAIL back_to_back: got %0d pulses cnt=%0d, required 256 pulses cnt=0",
                     good_seen - good_before, frame_cnt);
        end else begin
            passed = passed + 1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        byte_avail = 1'b0;
        byte_in    = 8'h00;
        model_clear();
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_terminal_count();
        test_sof_as_data();
        test_mid_frame_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
